// File: rtl/key_pkg.sv
// Shared types and constants for the key poll controller: FSM states,
// event-word layout and event FIFO geometry.
package key_pkg;

    typedef enum logic [1:0] {IDLE, REQ, CAP, UPD} key_state_e;

    localparam int KEY_W        = 8;
    localparam int EVT_W        = 16;
    localparam int EVT_MASK_OFF = 8;
    localparam int EVT_KEY_OFF  = 0;

    localparam int FIFO_DEPTH   = 4;
    localparam int FIFO_PTR_W   = 2;
    localparam int FIFO_CNT_W   = 3;

    // Event word: changed-bit mask above the new stable key state.
    function automatic logic [EVT_W-1:0] mk_evt(input logic [KEY_W-1:0] old_k,
                                                 input logic [KEY_W-1:0] new_k);
        logic [EVT_W-1:0] ev;
        ev = '0;
        ev[EVT_MASK_OFF +: KEY_W] = old_k ^ new_k;
        ev[EVT_KEY_OFF  +: KEY_W] = new_k;
        return ev;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// 4-deep key event FIFO; head is presented combinationally, and a push is
// accepted when full only if a pop happens in the same cycle.
module key_evt_fifo
    import key_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [EVT_W-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [EVT_W-1:0] head_o
);

    logic [EVT_W-1:0]      mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] rd_q, wr_q;
    logic [FIFO_CNT_W-1:0] cnt_q;
    logic                  pop_ok, push_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + FIFO_CNT_W'(push_ok) - FIFO_CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/key_poll_ctrl.sv
// Periodically reads the key PIO, debounces the 8 keys and queues one
// change event per accepted key state into a small FIFO.
module key_poll_ctrl
    import key_pkg::*;
#(
    parameter int               POLL_DIV  = 50000,
    parameter int               DEB_COUNT = 4,
    parameter logic [KEY_W-1:0] KEY_INIT  = 8'h00
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       pio_address,
    input  logic [KEY_W-1:0] pio_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EVT_W-1:0] evt_data,
    output logic [KEY_W-1:0] keys_stable,
    output logic             irq,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int               TMR_W    = $clog2(POLL_DIV);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_DIV - 3);
    localparam logic [3:0]       DEB      = 4'(DEB_COUNT);

    key_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [KEY_W-1:0] sample_q, sample_d;
    logic [KEY_W-1:0] last_q, last_d;
    logic [3:0]       cnt_q, cnt_d, cnt_nxt;
    logic [KEY_W-1:0] keys_q, keys_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, drop, full, empty;
    logic [EVT_W-1:0] push_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            sample_q <= '0;
            last_q   <= KEY_INIT;
            cnt_q    <= '0;
            keys_q   <= KEY_INIT;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sample_q <= sample_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            keys_q   <= keys_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        sample_d  = sample_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        cnt_nxt   = cnt_q;
        keys_d    = keys_q;
        push      = 1'b0;
        push_data = mk_evt(keys_q, sample_q);
        case (state_q)
            IDLE: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    state_d = REQ;
                end
            end
            REQ: state_d = CAP;
            CAP: begin
                sample_d = pio_readdata;
                state_d  = UPD;
            end
            UPD: begin
                // UPD is the first counted cycle of the next poll interval,
                // so IDLE after a poll is one cycle shorter than after reset.
                timer_d = timer_q + 1'b1;
                state_d = IDLE;
                if (sample_q == last_q) begin
                    cnt_nxt = (cnt_q >= DEB) ? DEB : cnt_q + 4'd1;
                end else begin
                    last_d  = sample_q;
                    cnt_nxt = 4'd1;
                end
                cnt_d = cnt_nxt;
                if (cnt_nxt == DEB && sample_q != keys_q) begin
                    push   = 1'b1;
                    keys_d = sample_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop  = evt_valid && evt_ready;
    assign drop = push && full && !pop;
    // A drop in the same cycle as a clear must leave the flag set.
    assign ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    key_evt_fifo u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (evt_data)
    );

    assign evt_valid   = !empty;
    assign irq         = evt_valid;
    assign overflow    = ovf_q;
    assign keys_stable = keys_q;
    assign pio_address = 2'd0;

endmodule

// File: tb/tb_key_poll_ctrl.sv
// Bench for key_poll_ctrl: directed scenarios plus random polls against a
// history-based debounce model and a queue model of the event FIFO.
module tb_key_poll_ctrl;

    localparam int PD  = 8;
    localparam int DEB = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  pio_address;
    logic [7:0]  pio_readdata = 8'h00;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [15:0] evt_data;
    logic [7:0]  keys_stable;
    logic        irq;
    logic        overflow;
    logic        ovf_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0]  hist[$];
    logic [7:0]  m_stable;
    logic [15:0] m_q[$];
    bit          m_ovf;

    key_poll_ctrl #(.POLL_DIV(PD), .DEB_COUNT(DEB), .KEY_INIT(8'h00)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pio_address  (pio_address),
        .pio_readdata (pio_readdata),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .keys_stable  (keys_stable),
        .irq          (irq),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        m_q.delete();
        m_stable = 8'h00;
        m_ovf    = 1'b0;
    endtask

    // Reset, released on a negedge; returns just after the first posedge.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full poll period. Key value is presented right after the previous
    // update edge; the DUT samples it 7 edges later and updates on the 8th.
    // evt_ready/ovf_clr are asserted only for that update edge.
    task automatic do_poll(input logic [7:0] val, input bit pop, input bit clr);
        logic [7:0]  exp_keys;
        logic [15:0] exp_head;
        bit          acc, drop;
        pio_readdata = val;
        repeat (7) @(posedge clk);
        @(negedge clk);
        exp_keys = m_stable;
        exp_head = (m_q.size() > 0) ? m_q[0] : 16'h0000;
        checks++;
        if (keys_stable !== exp_keys) begin
            failures++;
            $display("FAIL pre_update_keys got=%h exp=%h", keys_stable, exp_keys);
        end
        checks++;
        if (evt_data !== exp_head) begin
            failures++;
            $display("FAIL pre_update_head got=%h exp=%h", evt_data, exp_head);
        end
        evt_ready = pop;
        ovf_clr   = clr;
        @(posedge clk);
        @(negedge clk);
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        if (pop && m_q.size() > 0) void'(m_q.pop_front());
        hist.push_back(val);
        acc = (hist.size() >= DEB);
        for (int i = 0; i < DEB; i++)
            if (acc && hist[hist.size()-1-i] != val) acc = 1'b0;
        drop = 1'b0;
        if (acc && val != m_stable) begin
            if (m_q.size() < 4) m_q.push_back({val ^ m_stable, val});
            else drop = 1'b1;
            m_stable = val;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (keys_stable !== 8'h00) begin failures++; $display("FAIL rst_keys got=%h exp=00", keys_stable); end
        if (evt_valid !== 1'b0)    begin failures++; $display("FAIL rst_valid got=%b exp=0", evt_valid); end
        if (irq !== 1'b0)          begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
        if (overflow !== 1'b0)     begin failures++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        if (evt_data !== 16'h0)    begin failures++; $display("FAIL rst_data got=%h exp=0000", evt_data); end
        if (pio_address !== 2'd0)  begin failures++; $display("FAIL rst_addr got=%h exp=0", pio_address); end
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_single_event();
        do_reset();
        do_poll(8'h01, 0, 0);
        checks += 2;
        if (keys_stable !== 8'h00) begin failures++; $display("FAIL single_poll1_keys got=%h exp=00", keys_stable); end
        if (irq !== 1'b0)          begin failures++; $display("FAIL single_poll1_irq got=%b exp=0", irq); end
        do_poll(8'h01, 0, 0);
        checks += 3;
        if (keys_stable !== 8'h01) begin failures++; $display("FAIL single_keys got=%h exp=01", keys_stable); end
        if (evt_data !== 16'h0101) begin failures++; $display("FAIL single_data got=%h exp=0101", evt_data); end
        if (irq !== 1'b1)          begin failures++; $display("FAIL single_irq got=%b exp=1", irq); end
        do_poll(8'h01, 0, 0);
        checks++;
        if (irq !== 1'b1 || evt_data !== 16'h0101) begin
            failures++; $display("FAIL single_hold irq=%b data=%h exp irq=1 data=0101", irq, evt_data);
        end
        do_poll(8'h01, 1, 0);
        checks++;
        if (irq !== 1'b0 || evt_valid !== 1'b0) begin
            failures++; $display("FAIL single_popped irq=%b valid=%b exp 0 0", irq, evt_valid);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] seq [5];
        seq = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        do_reset();
        foreach (seq[i]) begin
            do_poll(seq[i], 0, 0);
            checks++;
            if (keys_stable !== 8'h00 || evt_valid !== 1'b0) begin
                failures++;
                $display("FAIL glitch_%0d keys=%h valid=%b exp keys=00 valid=0", i, keys_stable, evt_valid);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [5];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_reset();
        foreach (vals[i]) begin
            do_poll(vals[i], 0, 0);
            do_poll(vals[i], 0, 0);
        end
        checks += 4;
        if (keys_stable !== 8'h55) begin failures++; $display("FAIL ovf_keys got=%h exp=55", keys_stable); end
        if (overflow !== 1'b1)     begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        if (evt_data !== 16'h1111) begin failures++; $display("FAIL ovf_head got=%h exp=1111", evt_data); end
        if (m_q.size() != 4 || evt_valid !== 1'b1) begin
            failures++; $display("FAIL ovf_depth model=%0d valid=%b exp 4 1", m_q.size(), evt_valid);
        end
    endtask

    task automatic test_full_pop_push();
        do_poll(8'h55, 0, 1);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL clr_alone got=%b exp=0", overflow); end
        do_poll(8'h66, 0, 0);
        do_poll(8'h66, 1, 0);
        checks += 3;
        if (overflow !== 1'b0)     begin failures++; $display("FAIL fullpp_ovf got=%b exp=0", overflow); end
        if (evt_data !== 16'h3322) begin failures++; $display("FAIL fullpp_head got=%h exp=3322", evt_data); end
        if (keys_stable !== 8'h66) begin failures++; $display("FAIL fullpp_keys got=%h exp=66", keys_stable); end
    endtask

    task automatic test_ovf_clr_race();
        logic [15:0] exp [4];
        exp = '{16'h1133, 16'h7744, 16'h3366, 16'h0000};
        do_poll(8'h77, 0, 0);
        do_poll(8'h77, 0, 1);
        checks += 2;
        if (overflow !== 1'b1)     begin failures++; $display("FAIL race_ovf got=%b exp=1", overflow); end
        if (keys_stable !== 8'h77) begin failures++; $display("FAIL race_keys got=%h exp=77", keys_stable); end
        do_poll(8'h77, 0, 1);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL race_clr got=%b exp=0", overflow); end
        foreach (exp[i]) begin
            do_poll(8'h77, 1, 0);
            checks++;
            if (evt_data !== exp[i]) begin
                failures++; $display("FAIL drain_%0d got=%h exp=%h", i, evt_data, exp[i]);
            end
        end
        checks++;
        if (evt_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", evt_valid); end
    endtask

    task automatic test_reset_mid_cap();
        do_poll(8'h05, 0, 0);
        do_poll(8'h05, 0, 0);
        pio_readdata = 8'h3C;
        repeat (6) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (keys_stable !== 8'h00) begin failures++; $display("FAIL midcap_keys got=%h exp=00", keys_stable); end
        if (evt_valid !== 1'b0 || irq !== 1'b0) begin
            failures++; $display("FAIL midcap_valid valid=%b irq=%b exp 0 0", evt_valid, irq);
        end
        if (evt_data !== 16'h0)    begin failures++; $display("FAIL midcap_data got=%h exp=0000", evt_data); end
        if (overflow !== 1'b0)     begin failures++; $display("FAIL midcap_ovf got=%b exp=0", overflow); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        do_poll(8'h3C, 0, 0);
        do_poll(8'h3C, 0, 0);
        checks += 2;
        if (keys_stable !== 8'h3C) begin failures++; $display("FAIL postrst_keys got=%h exp=3C", keys_stable); end
        if (evt_data !== 16'h3C3C) begin failures++; $display("FAIL postrst_data got=%h exp=3C3C", evt_data); end
    endtask

    task automatic test_random();
        logic [7:0]  v;
        logic [15:0] exp_head;
        do_reset();
        v = 8'h00;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) v = 8'($urandom_range(0, 255));
            do_poll(v, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            exp_head = (m_q.size() > 0) ? m_q[0] : 16'h0000;
            checks++;
            if (keys_stable !== m_stable || evt_data !== exp_head ||
                evt_valid !== (m_q.size() > 0) || irq !== (m_q.size() > 0) ||
                overflow !== m_ovf) begin
                failures++;
                $display("FAIL rand_%0d keys=%h/%h data=%h/%h valid=%b irq=%b ovf=%b/%b", n,
                         keys_stable, m_stable, evt_data, exp_head, evt_valid, irq, overflow, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_glitch();
        test_overflow();
        test_full_pop_push();
        test_ovf_clr_race();
        test_reset_mid_cap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
